// File: rtl/posit_mac_seq.sv
`default_nettype none
// posit_mac_seq: byte-stream command sequencer for the posit MAC core.  Rev 1.0
// Optional mac_done watchdog enabled by defining POSIT_MAC_SEQ_TIMEOUT_EN.
module posit_mac_seq #(
   parameter int N       = 16,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [7:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] mac_a,
   output logic [N-1:0] mac_b,
   output logic         mac_start,
   output logic         mac_clr,
   input  logic         mac_done,
   input  logic [N-1:0] mac_acc,
   output logic         busy,
   output logic         err
);

   localparam int         NB      = N / 8;
   localparam logic [7:0] LAST    = 8'(NB - 1);
`ifdef POSIT_MAC_SEQ_TIMEOUT_EN
   localparam bit         TO_EN   = 1'b1;
`else
   localparam bit         TO_EN   = 1'b0;
`endif
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_CNT   = 3'd2,
      S_LDA   = 3'd3,
      S_LDB   = 3'd4,
      S_ISSUE = 3'd5,
      S_WAIT  = 3'd6,
      S_RD    = 3'd7
   } state_t;

   state_t       state;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic [N-1:0] shreg;
   logic [7:0]   cnt;
   logic [7:0]   idx;
   logic [15:0]  timer;
   logic         in_take;
   logic         out_take;

   assign in_take  = in_valid & in_ready;
   assign out_take = out_valid & out_ready;
   assign out_data = shreg[7:0];
   assign mac_a    = op_a;
   assign mac_b    = op_b;

   // Output flags of the state being entered: {in_ready, busy, mac_start, mac_clr, out_valid}
   function automatic logic [4:0] flags(input state_t s);
      logic [4:0] f;
      case (s)
         S_IDLE:              f = 5'b10000;
         S_CNT, S_LDA, S_LDB: f = 5'b11000;
         S_CLR:               f = 5'b01010;
         S_ISSUE:             f = 5'b01100;
         S_WAIT:              f = 5'b01000;
         S_RD:                f = 5'b01001;
         default:             f = 5'b10000;
      endcase
      return f;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_IDLE);
         op_a  <= '0;
         op_b  <= '0;
         shreg <= '0;
         cnt   <= '0;
         idx   <= '0;
         timer <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_take) begin
                  idx <= '0;
                  case (in_data)
                     8'h01: begin
                        err   <= 1'b0;
                        state <= S_CLR;
                        {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_CLR);
                     end
                     8'h02: begin
                        cnt   <= 8'd1;
                        state <= S_LDA;
                        {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_LDA);
                     end
                     8'h03: begin
                        shreg <= mac_acc;
                        state <= S_RD;
                        {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_RD);
                     end
                     8'h04: begin
                        state <= S_CNT;
                        {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_CNT);
                     end
                     default: err <= 1'b1;
                  endcase
               end
            end
            S_CLR: begin
               state <= S_IDLE;
               {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_IDLE);
            end
            S_CNT: begin
               if (in_take) begin
                  if (in_data == 8'd0) begin
                     state <= S_IDLE;
                     {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_IDLE);
                  end else begin
                     cnt   <= in_data;
                     state <= S_LDA;
                     {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_LDA);
                  end
               end
            end
            S_LDA: begin
               if (in_take) begin
                  // LSB-first: each new byte enters at the top and shifts down
                  op_a <= N'({in_data, op_a} >> 8);
                  if (idx == LAST) begin
                     idx   <= '0;
                     state <= S_LDB;
                     {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_LDB);
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end
            S_LDB: begin
               if (in_take) begin
                  op_b <= N'({in_data, op_b} >> 8);
                  if (idx == LAST) begin
                     idx   <= '0;
                     state <= S_ISSUE;
                     {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_ISSUE);
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end
            S_ISSUE: begin
               // The ISSUE cycle counts as the first watchdog cycle
               timer <= 16'd1;
               state <= S_WAIT;
               {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_WAIT);
            end
            S_WAIT: begin
               if (mac_done) begin
                  cnt <= cnt - 8'd1;
                  if (cnt == 8'd1) begin
                     state <= S_IDLE;
                     {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_IDLE);
                  end else begin
                     state <= S_LDA;
                     {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_LDA);
                  end
               end else if (TO_EN && (timer == TO_LAST)) begin
                  err   <= 1'b1;
                  cnt   <= '0;
                  state <= S_IDLE;
                  {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_IDLE);
               end else if (TO_EN) begin
                  timer <= timer + 16'd1;
               end
            end
            S_RD: begin
               if (out_take) begin
                  shreg <= shreg >> 8;
                  if (idx == LAST) begin
                     idx   <= '0;
                     state <= S_IDLE;
                     {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_IDLE);
                  end else begin
                     idx <= idx + 8'd1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               {in_ready, busy, mac_start, mac_clr, out_valid} <= flags(S_IDLE);
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_posit_mac_seq.sv
`default_nettype none
// tb_posit_mac_seq: directed bench with a MAC stub and an expected-transaction model.
module tb_posit_mac_seq;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   in_data = 8'h00;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] mac_a, mac_b;
   logic         mac_start, mac_clr;
   logic         mac_done = 1'b0;
   logic [N-1:0] mac_acc;
   logic         busy, err;

   posit_mac_seq #(.N(N), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .mac_a(mac_a), .mac_b(mac_b), .mac_start(mac_start), .mac_clr(mac_clr),
      .mac_done(mac_done), .mac_acc(mac_acc), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // MAC stub: done three cycles after start, acc += a*b modulo 2^N
   logic [N-1:0] stub_acc = '0;
   logic [N-1:0] pa = '0, pb = '0;
   int           dly = 0;
   logic         inject = 1'b0, never = 1'b0, acc_load = 1'b0;
   logic [N-1:0] acc_load_val = '0;
   assign mac_acc = stub_acc;

   always @(posedge clk) begin
      if (rst) begin
         dly      <= 0;
         mac_done <= 1'b0;
      end else begin
         mac_done <= (!never && dly == 2) || inject;
         if (mac_start) begin
            dly <= 3;
            pa  <= mac_a;
            pb  <= mac_b;
         end else if (dly != 0) begin
            dly <= dly - 1;
         end
         if (!never && dly == 2) stub_acc <= stub_acc + pa * pb;
         if (mac_clr) stub_acc <= '0;
         if (acc_load) stub_acc <= acc_load_val;
      end
   end

   // Expected transactions, produced by the stimulus from the command semantics
   typedef struct packed { logic [N-1:0] a; logic [N-1:0] b; } pair_t;
   pair_t        exp_pairs[$];
   logic [7:0]   exp_bytes[$];
   logic [N-1:0] model_acc = '0;
   int           n_start = 0, n_clr = 0;
   logic         in_op = 1'b0;
   logic [N-1:0] hold_a, hold_b;
   pair_t        p;
   logic [7:0]   eb;

   always @(negedge clk) begin
      if (rst) begin
         in_op = 1'b0;
      end else begin
         if (mac_start) begin
            n_start++;
            if (exp_pairs.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_start a=%0h b=%0h", mac_a, mac_b);
            end else begin
               p = exp_pairs.pop_front();
               chk("start_a", 32'(mac_a), 32'(p.a));
               chk("start_b", 32'(mac_b), 32'(p.b));
            end
            in_op  = 1'b1;
            hold_a = mac_a;
            hold_b = mac_b;
         end else if (in_op) begin
            chk("hold_a", 32'(mac_a), 32'(hold_a));
            chk("hold_b", 32'(mac_b), 32'(hold_b));
            if (mac_done || !busy) in_op = 1'b0;
         end
         if (mac_clr) n_clr++;
         if (out_valid && out_ready) begin
            if (exp_bytes.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out_byte actual=%0h", out_data);
            end else begin
               eb = exp_bytes.pop_front();
               chk("out_byte", 32'(out_data), 32'(eb));
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout byte=%0h in_ready=%0b required=1", b, in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
   endtask

   task automatic send_mac(input logic [15:0] a, input logic [15:0] b);
      exp_pairs.push_back({a, b});
      model_acc = model_acc + a * b;
      send_byte(8'h02);
      send_word(a);
      send_word(b);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(busy), 32'd0);
   endtask

   task automatic read_acc(input string name);
      exp_bytes.push_back(model_acc[7:0]);
      exp_bytes.push_back(model_acc[15:8]);
      send_byte(8'h03);
      wait_idle(name);
      chk({name, "_drained"}, 32'(exp_bytes.size()), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   int s0, c0, k;
   pair_t plist[3];

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mac_start", 32'(mac_start), 32'd0);
      chk("rst_mac_clr", 32'(mac_clr), 32'd0);
      chk("rst_mac_a", 32'(mac_a), 32'd0);
      rst = 1'b0;

      // Single MAC
      send_mac(16'h4000, 16'h5000);
      chk("mac_a_loaded", 32'(mac_a), 32'h4000);
      chk("mac_b_loaded", 32'(mac_b), 32'h5000);
      @(negedge clk);
      chk("start_after_last_b", 32'(mac_start), 32'd1);
      @(negedge clk);
      chk("start_one_cycle", 32'(mac_start), 32'd0);
      k = 0;
      while (!mac_done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", 32'(mac_done), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("busy_fall", 32'(busy), 32'd0);
      chk("single_start_count", 32'(n_start), 32'd1);

      // RD with a mid-stream stall
      @(posedge clk);
      #1 acc_load = 1'b1;
      acc_load_val = 16'h5000;
      @(posedge clk);
      #1 acc_load = 1'b0;
      model_acc = 16'h5000;
      exp_bytes.push_back(8'h00);
      exp_bytes.push_back(8'h50);
      send_byte(8'h03);
      @(negedge clk);
      chk("rd_valid", 32'(out_valid), 32'd1);
      chk("rd_first", 32'(out_data), 32'h00);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_hold", 32'(out_data), 32'h50);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_idle("rd_idle");
      chk("rd_drained", 32'(exp_bytes.size()), 32'd0);

      // MACN with 3 pairs
      plist[0] = {16'h0003, 16'h0005};
      plist[1] = {16'h0102, 16'h0010};
      plist[2] = {16'hFFFF, 16'h0002};
      s0 = n_start;
      send_byte(8'h04);
      send_byte(8'h03);
      for (int i = 0; i < 3; i++) begin
         exp_pairs.push_back(plist[i]);
         model_acc = model_acc + plist[i].a * plist[i].b;
         send_word(plist[i].a);
         send_word(plist[i].b);
      end
      wait_idle("macn_idle");
      chk("macn_starts", 32'(n_start - s0), 32'd3);
      chk("model_pin_macn", 32'(model_acc), 32'h602D);
      read_acc("rd_macn");

      // MACN with K=0
      s0 = n_start;
      send_byte(8'h04);
      send_byte(8'h00);
      @(negedge clk);
      chk("macn0_idle", 32'(busy), 32'd0);
      chk("macn0_ready", 32'(in_ready), 32'd1);
      repeat (5) @(negedge clk);
      chk("macn0_no_start", 32'(n_start - s0), 32'd0);

      // Bad opcode, CLR, stray mac_done
      s0 = n_start;
      send_byte(8'h7F);
      @(negedge clk);
      chk("bad_op_err", 32'(err), 32'd1);
      chk("bad_op_idle", 32'(busy), 32'd0);
      c0 = n_clr;
      send_byte(8'h01);
      @(negedge clk);
      chk("clr_pulse", 32'(mac_clr), 32'd1);
      chk("clr_err_cleared", 32'(err), 32'd0);
      chk("clr_not_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("clr_pulse_end", 32'(mac_clr), 32'd0);
      chk("clr_count", 32'(n_clr - c0), 32'd1);
      model_acc = '0;
      @(posedge clk);
      #1 inject = 1'b1;
      @(posedge clk);
      #1 inject = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_done_idle", 32'(busy), 32'd0);
      chk("stray_done_err", 32'(err), 32'd0);
      chk("bad_op_no_start", 32'(n_start - s0), 32'd0);
      read_acc("rd_cleared");

`ifdef POSIT_MAC_SEQ_TIMEOUT_EN
      // Watchdog with a MAC that never answers
      never = 1'b1;
      exp_pairs.push_back({16'h0001, 16'h0002});
      send_byte(8'h02);
      send_word(16'h0001);
      send_word(16'h0002);
      @(negedge clk);
      chk("to_start", 32'(mac_start), 32'd1);
      repeat (7) @(negedge clk);
      chk("to_still_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("to_idle", 32'(busy), 32'd0);
      chk("to_err", 32'(err), 32'd1);
      never = 1'b0;
      send_byte(8'h01);
      wait_idle("to_clr_idle");
`endif

      // Reset in the middle of LDB
      s0 = n_start;
      send_byte(8'h02);
      send_word(16'h2211);
      send_byte(8'h33);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ldb_idle", 32'(busy), 32'd0);
      chk("rst_ldb_ready", 32'(in_ready), 32'd1);
      chk("rst_ldb_a", 32'(mac_a), 32'd0);
      chk("rst_ldb_b", 32'(mac_b), 32'd0);
      repeat (4) @(negedge clk);
      chk("rst_ldb_no_start", 32'(n_start - s0), 32'd0);
      send_mac(16'h0007, 16'h0009);
      wait_idle("post_rst_mac");
      chk("model_pin_post_rst", 32'(model_acc), 32'h003F);
      read_acc("rd_post_rst");
      chk("pairs_drained", 32'(exp_pairs.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
